alu_op_sequencer: RTL

//  Issue stage directly upstream of the 32-bit gate-level ALU. Buffers {cmd,a,b} operations in a FIFO.

---
 rtl/alu_op_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Issue stage in front of an unclocked ripple-carry ALU. Operations {cmd,a,b}
// are queued in a small FIFO. The head operation is driven onto the ALU
// through registers and held for SETTLE_CYCLES edges so the carry chain can
// resolve. The ALU outputs are then captured, post-processed (SLT, flag
// masking, zero detect) and offered on a valid/ready result port.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               operation handshake (in_ready = FIFO not full)
//   in_cmd, in_a, in_b              0 ADD,1 SUB,2 XOR,3 SLT,4 AND,5 NAND,6 NOR,7 OR
//   alu_cmd, alu_a, alu_b           registered operation driven to the ALU
//   alu_res, alu_carryout,
//   alu_overflow                    combinational ALU outputs
//   out_valid/out_ready             result handshake
//   out_res, out_carryout,
//   out_overflow, out_zero          captured result and flags
//   busy                            operation in flight or queued
module alu_op_sequencer #(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_cmd,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [2:0]       alu_cmd,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_carryout,
    input  logic             alu_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_carryout,
    output logic             out_overflow,
    output logic             out_zero,
    output logic             busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] FULL        = CNT_W'(DEPTH);
    localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE_CYCLES - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] VALID  = 2'd2;

    localparam logic [2:0] CMD_ADD = 3'd0;
    localparam logic [2:0] CMD_SUB = 3'd1;
    localparam logic [2:0] CMD_SLT = 3'd3;

    // SLT is a subtraction; the true signed comparison is sign XOR overflow.
    function automatic logic [WIDTH-1:0] slt_result(input logic [WIDTH-1:0] diff,
                                                     input logic ovf);
        return {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ ovf};
    endfunction

    logic [2:0]       fifo_cmd [DEPTH];
    logic [WIDTH-1:0] fifo_a   [DEPTH];
    logic [WIDTH-1:0] fifo_b   [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [1:0]       state;
    logic [SET_W-1:0] settle_cnt;
    logic [2:0]       op_cmd;     // original command of the op on the ALU

    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [WIDTH-1:0] cap_res;
    logic             cap_carry;
    logic             cap_ovf;

    assign fifo_empty = (count == '0);
    assign in_ready   = (count < FULL);
    assign push       = in_valid && in_ready;
    // Head leaves the FIFO when the ALU is free: from IDLE, or on the same
    // edge the previous result is handed off.
    assign pop        = !fifo_empty &&
                        ((state == IDLE) || ((state == VALID) && out_ready));
    assign busy       = (state != IDLE) || !fifo_empty;

    // FIFO storage: data only, pointers carry the reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_cmd[wr_ptr] <= in_cmd;
            fifo_a[wr_ptr]   <= in_a;
            fifo_b[wr_ptr]   <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Capture post-processing of the settled ALU outputs.
    always_comb begin
        cap_res   = alu_res;
        cap_carry = 1'b0;
        cap_ovf   = 1'b0;
        case (op_cmd)
            CMD_ADD, CMD_SUB: begin
                cap_carry = alu_carryout;
                cap_ovf   = alu_overflow;
            end
            CMD_SLT: cap_res = slt_result(alu_res, alu_overflow);
            default: ;
        endcase
    end

    // Issue / settle / capture sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            op_cmd       <= '0;
            alu_cmd      <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            out_valid    <= 1'b0;
            out_res      <= '0;
            out_carryout <= 1'b0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) state <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end else begin
                        out_res      <= cap_res;
                        out_carryout <= cap_carry;
                        out_overflow <= cap_ovf;
                        out_zero     <= (cap_res == '0);
                        out_valid    <= 1'b1;
                        state        <= VALID;
                    end
                end
                VALID: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= fifo_empty ? IDLE : SETTLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (pop) begin
                op_cmd     <= fifo_cmd[rd_ptr];
                alu_cmd    <= (fifo_cmd[rd_ptr] == CMD_SLT) ? CMD_SUB : fifo_cmd[rd_ptr];
                alu_a      <= fifo_a[rd_ptr];
                alu_b      <= fifo_b[rd_ptr];
                settle_cnt <= SETTLE_INIT;
            end
        end
    end

endmodule
